// File: rtl/mux16_rr_sched.sv
// rtl/mux16_rr_sched.sv - round-robin owner scheduler for a shared 16:1 single-bit mux
//
// Purpose: grants one of 16 requesters ownership of a shared 16:1 mux.
//          Each grant is limited to MAX_HOLD cycles. A one-cycle dead gap
//          follows each grant so the mux output settles before the next
//          owner samples it.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   en      in   arbitration enable; blocks new grants only
//   req     in   [15:0] level-sensitive request vector
//   sel     out  [3:0] mux select for the current or most recent owner
//   gnt     out  [15:0] one-hot grant, zero when there is no owner
//   busy    out  high in GRANT and GAP
//   preempt out  one-cycle pulse when a grant is cut off by hold expiry
module mux16_rr_sched #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        busy,
    output logic        preempt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [15:0]       gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              preempt_q, preempt_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]        last_q, last_d;

    logic              win_found;
    logic [3:0]        win_idx;
    logic [3:0]        cand;
    logic              grant_start;
    logic              hold_expire;
    logic              owner_release;
    logic              grant_exit;

    // Circular priority scan starting just after the previous owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        cand      = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand = last_q + 4'd1 + 4'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant_start   = en && win_found;
    assign hold_expire   = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    assign owner_release = !req[sel_q];
    assign grant_exit    = owner_release || hold_expire;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_start) state_d = S_GRANT;
            S_GRANT: if (grant_exit)  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; every output leaves a flop.
    always_comb begin
        sel_d      = sel_q;
        gnt_d      = 16'd0;
        busy_d     = 1'b0;
        preempt_d  = 1'b0;
        hold_cnt_d = '0;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                if (grant_start) begin
                    sel_d  = win_idx;
                    gnt_d  = 16'd1 << win_idx;
                    busy_d = 1'b1;
                end
            end
            S_GRANT: begin
                busy_d = 1'b1;
                if (grant_exit) begin
                    last_d    = sel_q;
                    // A release on the expiry edge is voluntary, not a preempt.
                    preempt_d = hold_expire && !owner_release;
                end else begin
                    gnt_d      = gnt_q;
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 4'd0;
            gnt_q      <= 16'd0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= 4'd15;
        end else begin
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares one 16:1 single-bit mux among 16 requesters.
- Drives the mux select lines and a one-hot grant vector.
- Enforces a maximum hold time per grant and inserts a one-cycle dead gap between owners so the mux output settles before the next owner samples it.
- Sits directly in front of the 16:1 mux datapath; requesters see only req/gnt.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles per owner; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low blocks new grants but does not end a current grant.
- req  input  16  request vector; bit i = requester i; level-sensitive.
- sel  output  4  mux select; sel[0]=s0 ... sel[3]=s3; selects input d[sel].
- gnt  output  16  one-hot grant; all-zero when no owner.
- busy  output  1  high while in GRANT or GAP.
- preempt  output  1  one-cycle pulse when a grant is ended by MAX_HOLD expiry.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, gnt=0, busy=0, preempt=0, hold_cnt=0, last=15. The first search therefore starts at index 0.
- All outputs are registered; there is no combinational path from req to any output.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0, pick the first set bit scanning circularly from (last+1) mod 16 upward.
  - Next cycle: state=GRANT, sel=winner, gnt=1<<winner, busy=1, hold_cnt=0.
  - Otherwise stay in IDLE; sel keeps its previous value, so the mux input does not change while idle.
- Latency: req asserted before edge k (idle, en=1) -> gnt visible after edge k (1 cycle).
- GRANT:
  - hold_cnt increments every cycle.
  - Exit to GAP on the first edge where either:
    - req[sel]=0 (voluntary release), or
    - hold_cnt==MAX_HOLD-1 (forced).
  - On exit: gnt=0, last=sel, hold_cnt=0. preempt=1 for that one cycle only if the exit was forced and req[sel] was still 1.
  - Simultaneous release and expiry counts as a release: preempt=0.
  - en going low during GRANT has no effect on the current grant.
- GAP: exactly one cycle. gnt=0, sel unchanged, busy=1. Next state is IDLE; arbitration happens in IDLE.
- Steady state with all 16 requests held: each owner holds for MAX_HOLD cycles, then one GAP cycle, then one IDLE cycle. Period per owner = MAX_HOLD+2. Order is 0,1,...,15,0,...
- Wrap-around: when last=15 the search starts at 0; when last=i and only req[i] is set, i wins again (after GAP and IDLE).
- Fairness: a requester holding req continuously is granted within 15*(MAX_HOLD+2) cycles of entering the queue.
- A req pulse that drops before the IDLE sample is lost; no request latching.
- Invariants:
  - gnt is zero or one-hot.
  - When gnt!=0, gnt[sel]=1.
  - preempt is never high for two consecutive cycles.
- Reset mid-GRANT: outputs return to reset values immediately, asynchronously; last=15 again.

Test Plan:
- Reset then req=16'h0001, en=1 -> gnt=16'h0001, sel=0 one cycle later. Drop req after 3 GRANT cycles -> gnt=0 next edge, GAP, IDLE; preempt stays 0.
- req=16'hFFFF held, MAX_HOLD=8 -> grants 0,1,2,...,15,0 in order. Each gnt lasts 8 cycles, with 2 zero-grant cycles between grants, and a preempt pulse at each handover.
- req=16'h8001 held with last=15 after reset -> first grant to 0, then 15, then 0. Confirms wrap and skipping of idle bits 1..14.
- en=0 with req=16'h0010 -> no grant, sel stays 0. Raise en -> gnt=16'h0010, sel=4 after one edge. Drop en mid-grant -> grant runs its full MAX_HOLD.
- Release coinciding with the MAX_HOLD-1 count -> preempt=0.
- Assert rst_n=0 mid-GRANT with sel=7 -> gnt=0, sel=0, busy=0 with no clock edge. After release, req=16'h0080 is granted with sel=7.
